// File: rtl/scan_seq_pkg.sv
// Shared types for the scan sequencer: FSM state encoding and bit-counter sizing.
// No logic; imported by scan_seq_ctrl.
package scan_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CAPTURE,
      S_UNLOAD,
      S_DONE
   } scan_state_t;

   // Wide enough to hold 0..CHAIN_LEN.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register, shifting toward the MSB with serial input at bit 0.
// Latency: one cycle per load or shift; load has priority over shift; no backpressure.
module scan_shift_reg #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d    = q_q << 1;
         q_d[0] = sin;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/scan_seq_ctrl.sv
// Mux-D scan sequencer: load pattern MSB-first, one capture cycle, unload and compare.
// Latency start->done 2*CHAIN_LEN+1 cycles; start ignored while busy. SCAN_FAIL_CNT_EN adds fail_cnt.
module scan_seq_ctrl
   import scan_seq_pkg::*;
#(
   parameter int CHAIN_LEN = 3,
   parameter int PI_W      = 3
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pat_in,
   input  logic [PI_W-1:0]      pi_in,
   input  logic [CHAIN_LEN-1:0] exp_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] resp_out,
   output logic                 scan_m,
   output logic                 scan_i,
   input  logic                 scan_o,
   output logic [PI_W-1:0]      pi_out
`ifdef SCAN_FAIL_CNT_EN
   ,
   output logic [7:0]           fail_cnt
`endif
);

   localparam int CW = cnt_w(CHAIN_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   scan_state_t state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 scan_m_q, scan_m_d;
   logic [PI_W-1:0]      pi_out_q, pi_out_d;
   logic [PI_W-1:0]      pi_q, pi_d;
   logic [CHAIN_LEN-1:0] exp_q, exp_d;
   logic [CHAIN_LEN-1:0] resp_q, resp_d;

   logic                 ser_load, ser_shift;
   logic                 des_load, des_shift;
   logic [CHAIN_LEN-1:0] ser_q, des_q, des_nxt;
   logic                 ser_unused;

   // Serialiser shifts in zeros, so its MSB is already 0 once the pattern is out.
   scan_shift_reg #(.W(CHAIN_LEN)) u_ser (
      .clk      (clk),
      .n_reset  (n_reset),
      .load     (ser_load),
      .load_val (pat_in),
      .shift    (ser_shift),
      .sin      (1'b0),
      .q        (ser_q)
   );

   scan_shift_reg #(.W(CHAIN_LEN)) u_des (
      .clk      (clk),
      .n_reset  (n_reset),
      .load     (des_load),
      .load_val ('0),
      .shift    (des_shift),
      .sin      (scan_o),
      .q        (des_q)
   );

   assign ser_unused = ^ser_q;

   always_comb begin
      des_nxt    = des_q << 1;
      des_nxt[0] = scan_o;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      scan_m_d  = 1'b0;
      pi_out_d  = '0;
      pass_d    = pass_q;
      resp_d    = resp_q;
      pi_d      = pi_q;
      exp_d     = exp_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      des_load  = 1'b0;
      des_shift = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LOAD;
               cnt_d    = '0;
               busy_d   = 1'b1;
               scan_m_d = 1'b1;
               pi_d     = pi_in;
               exp_d    = exp_in;
               ser_load = 1'b1;
               des_load = 1'b1;
               pass_d   = 1'b0;
               resp_d   = '0;
            end
         end
         S_LOAD: begin
            busy_d    = 1'b1;
            ser_shift = 1'b1;
            if (cnt_q == LAST) begin
               state_d  = S_CAPTURE;
               pi_out_d = pi_q;
            end else begin
               cnt_d    = cnt_q + CW'(1);
               scan_m_d = 1'b1;
            end
         end
         S_CAPTURE: begin
            state_d  = S_UNLOAD;
            cnt_d    = '0;
            busy_d   = 1'b1;
            scan_m_d = 1'b1;
         end
         S_UNLOAD: begin
            des_shift = 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               resp_d  = des_nxt;
               pass_d  = (des_nxt == exp_q);
            end else begin
               cnt_d    = cnt_q + CW'(1);
               busy_d   = 1'b1;
               scan_m_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         scan_m_q <= 1'b0;
         pi_out_q <= '0;
         pi_q     <= '0;
         exp_q    <= '0;
         resp_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         scan_m_q <= scan_m_d;
         pi_out_q <= pi_out_d;
         pi_q     <= pi_d;
         exp_q    <= exp_d;
         resp_q   <= resp_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign resp_out = resp_q;
   assign scan_m   = scan_m_q;
   assign scan_i   = ser_q[CHAIN_LEN-1];
   assign pi_out   = pi_out_q;

`ifdef SCAN_FAIL_CNT_EN
   logic [7:0] fail_cnt_q, fail_cnt_d;

   always_comb begin
      fail_cnt_d = fail_cnt_q;
      if (done_d && !pass_d && (fail_cnt_q != 8'hFF)) begin
         fail_cnt_d = fail_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fail_cnt_q <= '0;
      end else begin
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with a behavioural scan chain (capture = state ^ pi).
// Runs a 3-flop instance and a 1-flop instance.
module tb_scan_seq_ctrl;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;

   logic       start = 1'b0;
   logic [2:0] pat_in = '0, pi_in = '0, exp_in = '0;
   logic       busy, done, pass, scan_m, scan_i, scan_o;
   logic [2:0] resp_out, pi_out;
   logic [2:0] chain = '0;

   logic       start1 = 1'b0;
   logic [0:0] pat1 = '0, exp1 = '0;
   logic [2:0] pi1 = '0;
   logic       busy1, done1, pass1, scan_m1, scan_i1, scan_o1;
   logic [0:0] resp1;
   logic [2:0] pi_out1;
   logic [0:0] chain1 = '0;

`ifdef SCAN_FAIL_CNT_EN
   logic [7:0] fail_cnt, fail_cnt1;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int cyc;

   always #5 clk = ~clk;

   scan_seq_ctrl #(.CHAIN_LEN(3), .PI_W(3)) u_dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .start    (start),
      .pat_in   (pat_in),
      .pi_in    (pi_in),
      .exp_in   (exp_in),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .resp_out (resp_out),
      .scan_m   (scan_m),
      .scan_i   (scan_i),
      .scan_o   (scan_o),
      .pi_out   (pi_out)
`ifdef SCAN_FAIL_CNT_EN
      ,
      .fail_cnt (fail_cnt)
`endif
   );

   scan_seq_ctrl #(.CHAIN_LEN(1), .PI_W(3)) u_dut1 (
      .clk      (clk),
      .n_reset  (n_reset),
      .start    (start1),
      .pat_in   (pat1),
      .pi_in    (pi1),
      .exp_in   (exp1),
      .busy     (busy1),
      .done     (done1),
      .pass     (pass1),
      .resp_out (resp1),
      .scan_m   (scan_m1),
      .scan_i   (scan_i1),
      .scan_o   (scan_o1),
      .pi_out   (pi_out1)
`ifdef SCAN_FAIL_CNT_EN
      ,
      .fail_cnt (fail_cnt1)
`endif
   );

   // Chain under test: position 0 nearest scan_i, scan_o from the last flop.
   assign scan_o  = chain[2];
   assign scan_o1 = chain1[0];

   always @(posedge clk) begin
      if (scan_m) chain <= {chain[1:0], scan_i};
      else        chain <= chain ^ pi_out;
      if (scan_m1) chain1 <= scan_i1;
      else         chain1 <= chain1 ^ pi_out1[0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_pass",   32'(pass), 32'd0);
      chk("rst_resp",   32'(resp_out), 32'd0);
      chk("rst_scan_m", 32'(scan_m), 32'd0);
      chk("rst_scan_i", 32'(scan_i), 32'd0);
      chk("rst_pi_out", 32'(pi_out), 32'd0);
      n_reset = 1'b1;

      // Reset during LOAD cycle 1 aborts at once
      @(negedge clk);
      pat_in = 3'b111; pi_in = 3'b010; exp_in = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_pre_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2 n_reset = 1'b0;
      #1;
      chk("abort_busy",   32'(busy), 32'd0);
      chk("abort_scan_m", 32'(scan_m), 32'd0);
      chk("abort_scan_i", 32'(scan_i), 32'd0);
      chk("abort_done",   32'(done), 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);

      // Full pass test, cycle by cycle; inputs change after start to prove latching
      pat_in = 3'b110; pi_in = 3'b101; exp_in = 3'b011; start = 1'b1;
      @(negedge clk);
      start = 1'b0; pat_in = 3'b000; pi_in = 3'b000; exp_in = 3'b000;
      chk("ld0_busy",   32'(busy), 32'd1);
      chk("ld0_scan_m", 32'(scan_m), 32'd1);
      chk("ld0_scan_i", 32'(scan_i), 32'd1);
      @(negedge clk);
      chk("ld1_scan_m", 32'(scan_m), 32'd1);
      chk("ld1_scan_i", 32'(scan_i), 32'd1);
      @(negedge clk);
      chk("ld2_scan_m", 32'(scan_m), 32'd1);
      chk("ld2_scan_i", 32'(scan_i), 32'd0);
      chk("ld2_pi_out", 32'(pi_out), 32'd0);
      @(negedge clk);
      chk("cap_scan_m", 32'(scan_m), 32'd0);
      chk("cap_scan_i", 32'(scan_i), 32'd0);
      chk("cap_pi_out", 32'(pi_out), 32'h5);
      @(negedge clk);
      chk("ul0_scan_m", 32'(scan_m), 32'd1);
      chk("ul0_pi_out", 32'(pi_out), 32'd0);
      chk("ul0_scan_o", 32'(scan_o), 32'd0);
      @(negedge clk);
      chk("ul1_scan_o", 32'(scan_o), 32'd1);
      @(negedge clk);
      chk("ul2_scan_o", 32'(scan_o), 32'd1);
      chk("ul2_done",   32'(done), 32'd0);
      chk("ul2_busy",   32'(busy), 32'd1);
      @(negedge clk);
      chk("dn_done",   32'(done), 32'd1);
      chk("dn_busy",   32'(busy), 32'd0);
      chk("dn_resp",   32'(resp_out), 32'h3);
      chk("dn_pass",   32'(pass), 32'd1);
      chk("dn_scan_m", 32'(scan_m), 32'd0);
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_resp", 32'(resp_out), 32'h3);
      chk("post_pass", 32'(pass), 32'd1);

      // Fail case: same stimulus, wrong expectation
      pat_in = 3'b110; pi_in = 3'b101; exp_in = 3'b111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      chk("fail_latency", 32'(cyc), 32'd7);
      chk("fail_pass",    32'(pass), 32'd0);
      chk("fail_resp",    32'(resp_out), 32'h3);
`ifdef SCAN_FAIL_CNT_EN
      chk("fail_cnt",     32'(fail_cnt), 32'd1);
`endif
      @(negedge clk);

      // Start pulsed during UNLOAD is ignored
      pat_in = 3'b110; pi_in = 3'b101; exp_in = 3'b011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      pat_in = 3'b001; exp_in = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ign_busy", 32'(busy), 32'd1);
      cyc = 5;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("busy_ign_latency", 32'(cyc), 32'd7);
      chk("busy_ign_resp",    32'(resp_out), 32'h3);
      chk("busy_ign_pass",    32'(pass), 32'd1);

      // Start in the cycle right after done is accepted
      @(negedge clk);
      pat_in = 3'b001; pi_in = 3'b000; exp_in = 3'b001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'd7);
      chk("b2b_resp",    32'(resp_out), 32'h1);
      chk("b2b_pass",    32'(pass), 32'd1);
`ifdef SCAN_FAIL_CNT_EN
      chk("b2b_fail_cnt", 32'(fail_cnt), 32'd1);
`endif

      // Single-flop chain
      @(negedge clk);
      pat1 = 1'b1; pi1 = 3'b000; exp1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("c1_ld_scan_m", 32'(scan_m1), 32'd1);
      chk("c1_ld_scan_i", 32'(scan_i1), 32'd1);
      @(negedge clk);
      chk("c1_cap_scan_m", 32'(scan_m1), 32'd0);
      chk("c1_cap_scan_i", 32'(scan_i1), 32'd0);
      @(negedge clk);
      chk("c1_ul_scan_m", 32'(scan_m1), 32'd1);
      chk("c1_ul_done",   32'(done1), 32'd0);
      @(negedge clk);
      chk("c1_done", 32'(done1), 32'd1);
      chk("c1_resp", 32'(resp1), 32'd1);
      chk("c1_pass", 32'(pass1), 32'd1);
      chk("c1_busy", 32'(busy1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
